// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encoding,
// FSM state encoding and wait-counter width.
package dmem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Synchronous 32-bit word array with per-byte write enables.
// One read port and one write port; contents are never reset.
module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// WAIT_STATES cycles, then completes it with a one-cycle response pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | req_ready=1, accepting; request fields taken live from inputs
// ST_WAIT | added latency; down-counter runs to terminal count 1
// ST_RESP | rsp_valid=1 for one cycle; array access happened on entry
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  state_e                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic        cap_wren;
  size_e       cap_size;
  logic        cap_uns;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        is_idle;
  logic        accept;
  logic        go_resp;
  logic        cur_wren;
  size_e       cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;

  logic [3:0]    wr_be;
  logic [31:0]   wr_word;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   ext;

  assign is_idle = (state == ST_IDLE);
  assign accept  = is_idle && req_valid;
  assign go_resp = (accept && (WAIT_STATES == 0)) ||
                   ((state == ST_WAIT) && (wait_cnt == WAIT_CNT_W'(1)));

  // With zero wait states the array is accessed on the accepting edge, so
  // the live inputs must be used before the capture registers are loaded.
  assign cur_wren  = is_idle ? req_wren          : cap_wren;
  assign cur_size  = is_idle ? size_e'(req_size) : cap_size;
  assign cur_addr  = is_idle ? req_addr          : cap_addr;
  assign cur_wdata = is_idle ? req_wdata         : cap_wdata;

  always_comb begin
    cur_err = 1'b0;
    case (cur_size)
      SZ_HALF:    cur_err = cur_addr[0];
      SZ_WORD:    cur_err = |cur_addr[1:0];
      SZ_ILLEGAL: cur_err = 1'b1;
      default:    cur_err = 1'b0;
    endcase
    if (cur_addr[31:2] >= 30'(DEPTH_WORDS)) cur_err = 1'b1;
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_word = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en    = go_resp &&  cur_wren && !cur_err;
  assign rd_en    = go_resp && !cur_wren && !cur_err;
  assign mem_addr = cur_addr[AW+1:2];

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_addr (mem_addr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (mem_addr),
    .rd_data (rd_word)
  );

  assign shifted = rd_word >> {cap_addr[1:0], 3'b000};

  always_comb begin
    ext = rd_word;
    case (cap_size)
      SZ_BYTE: ext = cap_uns ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ext = cap_uns ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = rd_word;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !rsp_error && !cap_wren) ? ext : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      cap_wren  <= 1'b0;
      cap_size  <= SZ_BYTE;
      cap_uns   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_wren  <= req_wren;
            cap_size  <= size_e'(req_size);
            cap_uns   <= req_unsigned;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (go_resp) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= cur_err;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (go_resp) begin
            state     <= ST_RESP;
            wait_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_error <= cur_err;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (1, 0 and 3 wait
// states) sharing request fields, checked against a queued expectation.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_wren, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        v   [3];
  logic        rdy [3];
  logic        vld [3];
  logic        er  [3];
  logic [31:0] rd  [3];

  int   ws [3] = '{1, 0, 3};
  exp_t sb [$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]),
    .req_wren(req_wren), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[0]),
    .rsp_rdata(rd[0]), .rsp_error(er[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]),
    .req_wren(req_wren), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[1]),
    .rsp_rdata(rd[1]), .rsp_error(er[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v[2]), .req_ready(rdy[2]),
    .req_wren(req_wren), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[2]),
    .rsp_rdata(rd[2]), .rsp_error(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; request fields are scrambled after acceptance
  // so the response must come from the captured copy.
  task automatic xact(input int sel, input logic wren, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    req_wren = wren; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; v[sel] = 1'b1;
    chk("ready_idle", 32'(rdy[sel]), 32'd1);
    @(posedge clk);
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        v[sel] = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_wren = ~wren; req_unsigned = ~uns;
      end
      if (vld[sel]) begin
        got = 1'b1; lat = k;
        break;
      end
      chk("rdata_quiet", rd[sel], 32'h0);
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      e = sb.pop_front();
      chk("latency", 32'(lat), 32'(ws[sel] + 1));
      chk("rdata", rd[sel], e.rdata);
      chk("error", 32'(er[sel]), 32'(e.err));
      @(negedge clk);
      chk("single_pulse", 32'(vld[sel]), 32'd0);
      chk("ready_back", 32'(rdy[sel]), 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    int   pulses;
    bit   exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0; v[2] = 1'b0;
    req_wren = 1'b0; req_size = W; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_valid", 32'(vld[s]), 32'd0);
      chk("rst_rdata", rd[s], 32'h0);
      chk("rst_error", 32'(er[s]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk("rel_ready", 32'(rdy[s]), 32'd1);

    // One wait state: word, byte and half traffic plus faults
    xact(0, 1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    xact(0, 0, W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    xact(0, 1, B, 0, 32'h13, 32'h00000080, 32'h0, 0);
    xact(0, 0, B, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    xact(0, 0, B, 1, 32'h13, 32'h0, 32'h00000080, 0);
    xact(0, 0, W, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    xact(0, 0, H, 0, 32'h11, 32'h0, 32'h0, 1);
    xact(0, 0, W, 0, 32'(DEPTH * 4), 32'h0, 32'h0, 1);
    xact(0, 1, X, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    xact(0, 1, H, 0, 32'h11, 32'h00001234, 32'h0, 1);
    xact(0, 1, W, 0, 32'h12, 32'h55555555, 32'h0, 1);
    xact(0, 0, W, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    xact(0, 1, H, 0, 32'h12, 32'hFFFF9876, 32'h0, 0);
    xact(0, 0, W, 0, 32'h10, 32'h0, 32'h9876BEEF, 0);
    xact(0, 0, H, 0, 32'h12, 32'h0, 32'hFFFF9876, 0);
    xact(0, 0, H, 1, 32'h12, 32'h0, 32'h00009876, 0);
    xact(0, 0, B, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    xact(0, 0, B, 1, 32'h11, 32'h0, 32'h000000BE, 0);

    // Zero wait states, req_valid held high across two transactions
    xact(1, 1, W, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    req_wren = 1'b0; req_size = W; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; v[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_ready", 32'(rdy[1]), 32'(exp_rdy[k]));
      if (rdy[1]) begin
        e.rdata = 32'hCAFEF00D; e.err = 1'b0;
        sb.push_back(e);
      end
      if (vld[1]) begin
        pulses++;
        chk("hold_sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("hold_rdata", rd[1], e.rdata);
          chk("hold_error", 32'(er[1]), 32'(e.err));
        end
      end
    end
    v[1] = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd2);
    @(negedge clk);
    chk("hold_no_extra", 32'(vld[1]), 32'd0);

    // Three wait states, reset during WAIT of a store
    xact(2, 1, W, 0, 32'h20, 32'hA5A5A5A5, 32'h0, 0);
    @(negedge clk);
    req_wren = 1'b1; req_size = W; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v[2] = 1'b0;
    chk("pre_rst_valid", 32'(vld[2]), 32'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_valid", 32'(vld[2]), 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(vld[2]), 32'd0);
      chk("abort_ready", 32'(rdy[2]), 32'd1);
    end
    xact(2, 0, W, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0);
    xact(0, 0, W, 0, 32'h10, 32'h0, 32'h9876BEEF, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
